fft16_frame_loader: RTL and testbench
=====================================

FFT16_FRAME_LOADER -- requirements
Module: fft16_frame_loader

Interface
REQ-001 SHALL have parameter N, default 16, meaning the width of each real and imaginary sample in two's complement.
REQ-002 SHALL have parameter PTS, default 16, meaning the points per frame; only 16 is supported.
REQ-003 SHALL have port clk, input, 1, meaning the single clock; all state changes on the rising edge.
REQ-004 SHALL have port rst, input, 1, meaning asynchronous active-high reset.
REQ-005 SHALL have port in_valid, input, 1, meaning in_re/in_im/in_last carry a sample.
REQ-006 SHALL have port in_re, input, N, meaning the real part of the sample.
REQ-007 SHALL have port in_im, input, N, meaning the imaginary part of the sample.
REQ-008 SHALL have port in_last, input, 1, meaning the source marks this as sample 15 of its frame.
REQ-009 SHALL have port in_ready, output, 1, meaning the loader can accept a sample this cycle.
REQ-010 SHALL have port frame_re, output, PTS*N, meaning the real parts; slot k is at bits [k*N +: N] and drives the FFT input Xkr.
REQ-011 SHALL have port frame_im, output, PTS*N, meaning the imaginary parts in the same layout; slot k drives Xki.
REQ-012 SHALL have port frame_valid, output, 1, meaning frame_re/frame_im hold a complete frame.
REQ-013 SHALL have port frame_ack, input, 1, meaning the downstream FFT stage has consumed the presented frame.
REQ-014 SHALL have port align_err, output, 1, meaning a one-cycle pulse on an in_last/pointer mismatch.
REQ-015 SHALL have port frame_cnt, output, 8, meaning the number of frames completed, wrapping modulo 256.

Function
REQ-016 SHALL accept a sample only on a cycle with in_valid=1 and in_ready=1.
REQ-017 SHALL implement two banks (A and B) of PTS complex entries, a 4-bit write pointer wptr, a write-bank select wsel, a read-bank select rsel, and a full flag per bank.
REQ-018 SHALL compute in_ready = ~full[wsel] combinationally.
REQ-019 SHALL write an accepted sample to bank wsel at slot wptr, then increment wptr, wrapping from 15 to 0.
REQ-020 SHALL, on accepting slot 15, set full[wsel], toggle wsel, and increment frame_cnt.
REQ-021 SHALL compute frame_valid = full[rsel] and drive frame_re/frame_im from bank rsel.
REQ-022 SHALL assert frame_valid on the cycle after slot 15 is accepted (latency 1) and hold the frame stable until acknowledged.
REQ-023 SHALL, on frame_valid=1 and frame_ack=1, clear full[rsel] and toggle rsel the next cycle.
REQ-024 SHALL ignore frame_ack while frame_valid=0.
REQ-025 SHALL, when the last write of one bank and the ack of the other occur in the same cycle, apply both updates with no lost frame.
REQ-026 SHALL, when both banks are full, hold in_ready=0 until an ack and leave wptr unchanged.
REQ-027 SHALL sustain one sample per cycle with frame_ack tied high and never deassert in_ready.
REQ-028 SHALL, on an accepted in_last=1 with wptr!=15, store the sample, discard the partial frame, set wptr=0, leave full flags and frame_cnt unchanged, and pulse align_err.
REQ-029 SHALL, on accepting slot 15 with in_last=0, complete the frame normally and pulse align_err.
REQ-030 SHALL pass samples through unmodified, with no scaling, reordering, or sign change.

Reset
REQ-031 SHALL, on rst=1 and independent of clk, clear wptr, wsel, rsel, both full flags, frame_cnt, and align_err.
REQ-032 SHALL zero both banks during reset, so frame_re/frame_im read 0, frame_valid=0, and in_ready=1.
REQ-033 SHALL, on rst asserted mid-frame, discard the partial frame; the first accepted sample after release lands in slot 0 of bank A.

Structure
REQ-034 SHALL place N, PTS, the pointer width, and the slot-index helper constants in shared package fft16_pkg, which the FFT stage also uses.
REQ-035 SHALL use one sub-module, fft16_bank: a 16-entry complex register bank with write enable and address and a flat PTS*N read-out, instantiated twice.

Verification
REQ-036 SHALL cover: reset, then 16 samples re=0,1,1,0 repeating, im=0, in_last on the 16th -> frame_valid one cycle later; frame_re slots 1,2,5,6,9,10,13,14 = 1, others 0; frame_cnt=1.
REQ-037 SHALL cover: 32 back-to-back samples re=k, im=-k, frame_ack=0 -> both banks full, in_ready=0 after sample 31, frame 0 presented first; one ack -> frame 1 presented with slot k re=16+k.
REQ-038 SHALL cover: frame_ack=1 continuously, 64 samples streamed -> in_ready stays 1, four frames, frame_cnt=4.
REQ-039 SHALL cover: in_last on sample 9 -> one-cycle align_err pulse, no frame_valid; the next 16 samples form a frame with the first at slot 0.
REQ-040 SHALL cover: rst pulsed after 7 samples -> all outputs zero and in_ready=1; 16 new samples -> a frame with exactly those values.
REQ-041 SHALL cover: ack of bank A in the same cycle as the slot-15 write of bank B -> bank B presented next cycle and in_ready stays 1.

Source files
------------

// File: rtl/fft16_pkg.sv
// Shared constants for the 16-point FFT datapath: sample width, frame size,
// write-pointer width and the flat-bus slot indexing helper.
package fft16_pkg;

  localparam int FFT_N    = 16;
  localparam int FFT_PTS  = 16;
  localparam int PTR_W    = 4;
  localparam int FCNT_W   = 8;

  localparam logic [PTR_W-1:0] LAST_SLOT = PTR_W'(FFT_PTS - 1);

  // Low bit of slot k on a flat PTS*w bus.
  function automatic int slot_lo(input int k, input int w);
    return k * w;
  endfunction

endpackage

// File: rtl/fft16_bank.sv
// One 16-entry complex register bank: single write port by slot address,
// whole bank visible as flat real/imaginary buses.
module fft16_bank
  import fft16_pkg::*;
#(
  parameter int N   = FFT_N,
  parameter int PTS = FFT_PTS
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             we_i,
  input  logic [PTR_W-1:0] addr_i,
  input  logic [N-1:0]     re_i,
  input  logic [N-1:0]     im_i,
  output logic [PTS*N-1:0] re_o,
  output logic [PTS*N-1:0] im_o
);

  logic [PTS*N-1:0] re_q;
  logic [PTS*N-1:0] im_q;

  // Contents are cleared on reset so a freshly reset loader presents zeros.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      re_q <= '0;
      im_q <= '0;
    end else if (we_i) begin
      re_q[slot_lo(int'(addr_i), N) +: N] <= re_i;
      im_q[slot_lo(int'(addr_i), N) +: N] <= im_i;
    end
  end

  assign re_o = re_q;
  assign im_o = im_q;

endmodule

// File: rtl/fft16_frame_loader.sv
// Ping-pong frame loader: gathers 16 complex samples into one bank while the
// other bank is presented, whole, to the FFT stage until it acknowledges.
module fft16_frame_loader
  import fft16_pkg::*;
#(
  parameter int N   = FFT_N,
  parameter int PTS = FFT_PTS
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  input  logic signed [N-1:0] in_re,
  input  logic signed [N-1:0] in_im,
  input  logic                in_last,
  output logic                in_ready,
  output logic [PTS*N-1:0]    frame_re,
  output logic [PTS*N-1:0]    frame_im,
  output logic                frame_valid,
  input  logic                frame_ack,
  output logic                align_err,
  output logic [FCNT_W-1:0]   frame_cnt
);

  logic [PTR_W-1:0]  wptr_q, wptr_d;
  logic              wsel_q, wsel_d;
  logic              rsel_q, rsel_d;
  logic [1:0]        full_q, full_d;
  logic [FCNT_W-1:0] cnt_q, cnt_d;
  logic              align_q, align_d;

  logic              accept;
  logic              at_last;
  logic              ack_take;
  logic [1:0]        bank_we;
  logic [PTS*N-1:0]  a_re, a_im, b_re, b_im;

  assign in_ready    = ~full_q[wsel_q];
  assign frame_valid = full_q[rsel_q];
  assign accept      = in_valid & in_ready;
  assign at_last     = (wptr_q == LAST_SLOT);
  assign ack_take    = frame_valid & frame_ack;
  assign bank_we[0]  = accept & ~wsel_q;
  assign bank_we[1]  = accept &  wsel_q;

  // Write and read sides touch different banks' full flags (the write bank is
  // never full when accepting, the read bank always is when acked), so both
  // updates can land in the same cycle.
  always_comb begin
    wptr_d  = wptr_q;
    wsel_d  = wsel_q;
    rsel_d  = rsel_q;
    full_d  = full_q;
    cnt_d   = cnt_q;
    align_d = 1'b0;
    if (accept) begin
      if (at_last) begin
        full_d[wsel_q] = 1'b1;
        wsel_d         = ~wsel_q;
        wptr_d         = '0;
        cnt_d          = cnt_q + 8'd1;
        align_d        = ~in_last;
      end else if (in_last) begin
        wptr_d  = '0;
        align_d = 1'b1;
      end else begin
        wptr_d = wptr_q + PTR_W'(1);
      end
    end
    if (ack_take) begin
      full_d[rsel_q] = 1'b0;
      rsel_d         = ~rsel_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q  <= '0;
      wsel_q  <= 1'b0;
      rsel_q  <= 1'b0;
      full_q  <= '0;
      cnt_q   <= '0;
      align_q <= 1'b0;
    end else begin
      wptr_q  <= wptr_d;
      wsel_q  <= wsel_d;
      rsel_q  <= rsel_d;
      full_q  <= full_d;
      cnt_q   <= cnt_d;
      align_q <= align_d;
    end
  end

  fft16_bank #(.N(N), .PTS(PTS)) u_bank_a (
    .clk_i  (clk),
    .rst_i  (rst),
    .we_i   (bank_we[0]),
    .addr_i (wptr_q),
    .re_i   (in_re),
    .im_i   (in_im),
    .re_o   (a_re),
    .im_o   (a_im)
  );

  fft16_bank #(.N(N), .PTS(PTS)) u_bank_b (
    .clk_i  (clk),
    .rst_i  (rst),
    .we_i   (bank_we[1]),
    .addr_i (wptr_q),
    .re_i   (in_re),
    .im_i   (in_im),
    .re_o   (b_re),
    .im_o   (b_im)
  );

  assign frame_re  = rsel_q ? b_re : a_re;
  assign frame_im  = rsel_q ? b_im : a_im;
  assign align_err = align_q;
  assign frame_cnt = cnt_q;

endmodule

// File: tb/tb_fft16_frame_loader.sv
// Randomised scenario bench for fft16_frame_loader against a queue-of-frames model.
module tb_fft16_frame_loader;

  localparam int N   = 16;
  localparam int PTS = 16;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic [N-1:0]     in_re = '0;
  logic [N-1:0]     in_im = '0;
  logic             in_last = 1'b0;
  logic             in_ready;
  logic [PTS*N-1:0] frame_re, frame_im;
  logic             frame_valid;
  logic             frame_ack = 1'b0;
  logic             align_err;
  logic [7:0]       frame_cnt;

  int vecs = 0;
  int errs = 0;

  // Model: completed frames waiting for the FFT, plus the frame being gathered.
  logic [PTS*N-1:0] mq_re[$];
  logic [PTS*N-1:0] mq_im[$];
  logic [PTS*N-1:0] part_re, part_im;
  int               pcount;
  int               mcnt;
  bit               exp_align;

  fft16_frame_loader #(.N(N), .PTS(PTS)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_re       (in_re),
    .in_im       (in_im),
    .in_last     (in_last),
    .in_ready    (in_ready),
    .frame_re    (frame_re),
    .frame_im    (frame_im),
    .frame_valid (frame_valid),
    .frame_ack   (frame_ack),
    .align_err   (align_err),
    .frame_cnt   (frame_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic model_reset();
    mq_re.delete();
    mq_im.delete();
    part_re   = '0;
    part_im   = '0;
    pcount    = 0;
    mcnt      = 0;
    exp_align = 1'b0;
  endtask

  function automatic bit exp_valid();
    return mq_re.size() > 0;
  endfunction

  function automatic bit exp_ready();
    return mq_re.size() < 2;
  endfunction

  // One clock: apply inputs, let the edge pass, advance the model.
  task automatic drive(input bit v, input logic [N-1:0] re, input logic [N-1:0] im,
                       input bit last, input bit ack);
    bit acc, ack_e;
    @(negedge clk);
    in_valid  = v;
    in_re     = re;
    in_im     = im;
    in_last   = last;
    frame_ack = ack;
    acc   = v && exp_ready();
    ack_e = ack && exp_valid();
    @(posedge clk);
    #1;
    exp_align = 1'b0;
    if (ack_e) begin
      void'(mq_re.pop_front());
      void'(mq_im.pop_front());
    end
    if (acc) begin
      part_re[pcount*N +: N] = re;
      part_im[pcount*N +: N] = im;
      if (pcount == PTS-1) begin
        mq_re.push_back(part_re);
        mq_im.push_back(part_im);
        mcnt      = (mcnt + 1) % 256;
        pcount    = 0;
        exp_align = !last;
      end else if (last) begin
        pcount    = 0;
        exp_align = 1'b1;
      end else begin
        pcount++;
      end
    end
    in_valid  = 1'b0;
    in_last   = 1'b0;
    frame_ack = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    #2;
    vecs++; if (frame_re !== '0) begin errs++; $display("FAIL reset_frame_re got %h want 0", frame_re); end
    vecs++; if (frame_im !== '0) begin errs++; $display("FAIL reset_frame_im got %h want 0", frame_im); end
    vecs++; if (frame_valid !== 1'b0) begin errs++; $display("FAIL reset_frame_valid got %b want 0", frame_valid); end
    vecs++; if (in_ready !== 1'b1) begin errs++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    vecs++; if (frame_cnt !== 8'd0) begin errs++; $display("FAIL reset_frame_cnt got %0d want 0", frame_cnt); end
    vecs++; if (align_err !== 1'b0) begin errs++; $display("FAIL reset_align_err got %b want 0", align_err); end
    model_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_pattern();
    logic [PTS*N-1:0] want;
    logic [N-1:0]     v;
    want = '0;
    for (int k = 0; k < PTS; k++) begin
      v = ((k % 4) == 1 || (k % 4) == 2) ? N'(1) : N'(0);
      want[k*N +: N] = v;
      drive(1'b1, v, '0, k == PTS-1, 1'b0);
      if (k < PTS-1) begin
        vecs++; if (frame_valid !== 1'b0) begin errs++; $display("FAIL pattern_early_valid k=%0d got %b want 0", k, frame_valid); end
      end
    end
    vecs++; if (frame_valid !== 1'b1) begin errs++; $display("FAIL pattern_valid got %b want 1", frame_valid); end
    vecs++; if (frame_re !== want) begin errs++; $display("FAIL pattern_re got %h want %h", frame_re, want); end
    vecs++; if (frame_im !== '0) begin errs++; $display("FAIL pattern_im got %h want 0", frame_im); end
    vecs++; if (frame_cnt !== 8'd1) begin errs++; $display("FAIL pattern_cnt got %0d want 1", frame_cnt); end
    vecs++; if (align_err !== 1'b0) begin errs++; $display("FAIL pattern_align got %b want 0", align_err); end
    drive(1'b0, '0, '0, 1'b0, 1'b1);
    vecs++; if (frame_valid !== 1'b0) begin errs++; $display("FAIL pattern_ack got %b want 0", frame_valid); end
  endtask

  task automatic test_back_to_back();
    logic [PTS*N-1:0] w_re, w_im;
    for (int k = 0; k < 2*PTS; k++) begin
      drive(1'b1, N'(k), N'(-k), (k % PTS) == PTS-1, 1'b0);
      vecs++; if (in_ready !== exp_ready()) begin errs++; $display("FAIL b2b_ready k=%0d got %b want %b", k, in_ready, exp_ready()); end
    end
    vecs++; if (in_ready !== 1'b0) begin errs++; $display("FAIL b2b_full_ready got %b want 0", in_ready); end
    for (int k = 0; k < PTS; k++) begin
      w_re[k*N +: N] = N'(k);
      w_im[k*N +: N] = N'(-k);
    end
    vecs++; if (frame_re !== w_re || frame_im !== w_im) begin errs++; $display("FAIL b2b_frame0 got %h/%h want %h/%h", frame_re, frame_im, w_re, w_im); end
    // Offered while both banks are full: must be refused.
    drive(1'b1, 16'hdead, 16'hbeef, 1'b0, 1'b0);
    vecs++; if (frame_re !== w_re) begin errs++; $display("FAIL b2b_hold got %h want %h", frame_re, w_re); end
    drive(1'b0, '0, '0, 1'b0, 1'b1);
    for (int k = 0; k < PTS; k++) begin
      w_re[k*N +: N] = N'(PTS + k);
      w_im[k*N +: N] = N'(-(PTS + k));
    end
    vecs++; if (frame_valid !== 1'b1) begin errs++; $display("FAIL b2b_valid1 got %b want 1", frame_valid); end
    vecs++; if (frame_re !== w_re || frame_im !== w_im) begin errs++; $display("FAIL b2b_frame1 got %h/%h want %h/%h", frame_re, frame_im, w_re, w_im); end
    vecs++; if (in_ready !== 1'b1) begin errs++; $display("FAIL b2b_ready_after_ack got %b want 1", in_ready); end
    vecs++; if (frame_cnt !== 8'(mcnt)) begin errs++; $display("FAIL b2b_cnt got %0d want %0d", frame_cnt, mcnt); end
    drive(1'b0, '0, '0, 1'b0, 1'b1);
    vecs++; if (frame_valid !== 1'b0) begin errs++; $display("FAIL b2b_drain got %b want 0", frame_valid); end
  endtask

  task automatic test_stream();
    int start;
    start = mcnt;
    for (int k = 0; k < 4*PTS; k++) begin
      drive(1'b1, N'($urandom), N'($urandom), (k % PTS) == PTS-1, 1'b1);
      vecs++; if (in_ready !== 1'b1) begin errs++; $display("FAIL stream_ready k=%0d got %b want 1", k, in_ready); end
      vecs++; if (frame_valid !== exp_valid()) begin errs++; $display("FAIL stream_valid k=%0d got %b want %b", k, frame_valid, exp_valid()); end
      if (exp_valid()) begin
        vecs++; if (frame_re !== mq_re[0] || frame_im !== mq_im[0]) begin errs++; $display("FAIL stream_frame k=%0d got %h want %h", k, frame_re, mq_re[0]); end
      end
    end
    vecs++; if (frame_cnt !== 8'(start + 4)) begin errs++; $display("FAIL stream_cnt got %0d want %0d", frame_cnt, (start + 4) % 256); end
    drive(1'b0, '0, '0, 1'b0, 1'b1);
    vecs++; if (frame_valid !== 1'b0) begin errs++; $display("FAIL stream_drain got %b want 0", frame_valid); end
  endtask

  task automatic test_misalign();
    logic [N-1:0] first;
    for (int k = 0; k < 9; k++) begin
      drive(1'b1, N'($urandom), N'($urandom), k == 8, 1'b0);
      vecs++; if (frame_valid !== 1'b0) begin errs++; $display("FAIL mis_valid k=%0d got %b want 0", k, frame_valid); end
      vecs++; if (align_err !== exp_align) begin errs++; $display("FAIL mis_align k=%0d got %b want %b", k, align_err, exp_align); end
    end
    vecs++; if (align_err !== 1'b1) begin errs++; $display("FAIL mis_pulse got %b want 1", align_err); end
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    vecs++; if (align_err !== 1'b0) begin errs++; $display("FAIL mis_pulse_end got %b want 0", align_err); end
    first = N'($urandom);
    for (int k = 0; k < PTS; k++)
      drive(1'b1, (k == 0) ? first : N'($urandom), N'($urandom), k == PTS-1, 1'b0);
    vecs++; if (frame_valid !== 1'b1) begin errs++; $display("FAIL mis_frame_valid got %b want 1", frame_valid); end
    vecs++; if (frame_re[0 +: N] !== first) begin errs++; $display("FAIL mis_slot0 got %h want %h", frame_re[0 +: N], first); end
    vecs++; if (frame_re !== mq_re[0] || frame_im !== mq_im[0]) begin errs++; $display("FAIL mis_frame got %h want %h", frame_re, mq_re[0]); end
    drive(1'b0, '0, '0, 1'b0, 1'b1);
    // Full frame whose slot 15 lacks in_last: completes but flags misalignment.
    for (int k = 0; k < PTS; k++)
      drive(1'b1, N'($urandom), N'($urandom), 1'b0, 1'b0);
    vecs++; if (align_err !== 1'b1) begin errs++; $display("FAIL nolast_align got %b want 1", align_err); end
    vecs++; if (frame_valid !== 1'b1) begin errs++; $display("FAIL nolast_valid got %b want 1", frame_valid); end
    vecs++; if (frame_re !== mq_re[0] || frame_im !== mq_im[0]) begin errs++; $display("FAIL nolast_frame got %h want %h", frame_re, mq_re[0]); end
    vecs++; if (frame_cnt !== 8'(mcnt)) begin errs++; $display("FAIL nolast_cnt got %0d want %0d", frame_cnt, mcnt); end
    drive(1'b0, '0, '0, 1'b0, 1'b1);
  endtask

  task automatic test_reset_mid();
    logic [PTS*N-1:0] w_re, w_im;
    for (int k = 0; k < 7; k++)
      drive(1'b1, N'($urandom), N'($urandom), 1'b0, 1'b0);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    vecs++; if (frame_re !== '0 || frame_im !== '0) begin errs++; $display("FAIL rmid_frame got %h/%h want 0", frame_re, frame_im); end
    vecs++; if (frame_valid !== 1'b0 || align_err !== 1'b0 || frame_cnt !== 8'd0) begin errs++; $display("FAIL rmid_ctrl got v=%b a=%b c=%0d want 0", frame_valid, align_err, frame_cnt); end
    vecs++; if (in_ready !== 1'b1) begin errs++; $display("FAIL rmid_ready got %b want 1", in_ready); end
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < PTS; k++) begin
      w_re[k*N +: N] = N'($urandom);
      w_im[k*N +: N] = N'($urandom);
      drive(1'b1, w_re[k*N +: N], w_im[k*N +: N], k == PTS-1, 1'b0);
    end
    vecs++; if (frame_valid !== 1'b1) begin errs++; $display("FAIL rmid_valid got %b want 1", frame_valid); end
    vecs++; if (frame_re !== w_re || frame_im !== w_im) begin errs++; $display("FAIL rmid_data got %h want %h", frame_re, w_re); end
    vecs++; if (frame_cnt !== 8'd1) begin errs++; $display("FAIL rmid_cnt got %0d want 1", frame_cnt); end
    drive(1'b0, '0, '0, 1'b0, 1'b1);
  endtask

  task automatic test_same_cycle();
    logic [PTS*N-1:0] b_re, b_im;
    logic [N-1:0]     r, i;
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < PTS; k++)
      drive(1'b1, N'($urandom), N'($urandom), k == PTS-1, 1'b0);
    for (int k = 0; k < PTS; k++) begin
      r = N'($urandom);
      i = N'($urandom);
      b_re[k*N +: N] = r;
      b_im[k*N +: N] = i;
      drive(1'b1, r, i, k == PTS-1, k == PTS-1);
      vecs++; if (in_ready !== 1'b1) begin errs++; $display("FAIL same_ready k=%0d got %b want 1", k, in_ready); end
    end
    vecs++; if (frame_valid !== 1'b1) begin errs++; $display("FAIL same_valid got %b want 1", frame_valid); end
    vecs++; if (frame_re !== b_re || frame_im !== b_im) begin errs++; $display("FAIL same_frame got %h want %h", frame_re, b_re); end
    vecs++; if (frame_cnt !== 8'd2) begin errs++; $display("FAIL same_cnt got %0d want 2", frame_cnt); end
    vecs++; if (mq_re.size() != 1 || frame_re !== mq_re[0]) begin errs++; $display("FAIL same_model got %h want %h", frame_re, b_re); end
    drive(1'b0, '0, '0, 1'b0, 1'b1);
    vecs++; if (frame_valid !== 1'b0) begin errs++; $display("FAIL same_drain got %b want 0", frame_valid); end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_pattern();
    test_back_to_back();
    test_stream();
    test_misalign();
    test_reset_mid();
    test_same_cycle();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
